// File: rtl/accel_job_sequencer.sv
// Host-side job sequencer: streams picture then weight words into the accelerator's ext
// memories, kicks the accelerator, waits for done (bounded), and hands the label to the CPU.
module accel_job_sequencer #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 7,
  parameter int PIC_WORDS   = 98,
  parameter int WGT_WORDS   = 128,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_go,
  input  logic              cmd_skip_wgt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              pic_we,
  output logic [ADDR_W-1:0] pic_addr,
  output logic              wgt_we,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [3:0]        acc_label,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_label,
  output logic              res_timeout,
  output logic              seq_busy
);

  // One extra count bit so a full 2**ADDR_W word load reaches its last-word compare cleanly.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]  PIC_LAST  = CNT_W'(PIC_WORDS - 1);
  localparam logic [CNT_W-1:0]  WGT_LAST  = CNT_W'(WGT_WORDS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PIC,
    LOAD_WGT,
    FLUSH,
    START,
    WAIT,
    RESULT
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [TCNT_W-1:0]   tcnt_reg;
  logic                skip_reg;
  logic                pic_we_reg;
  logic [ADDR_W-1:0]   pic_addr_reg;
  logic                wgt_we_reg;
  logic [ADDR_W-1:0]   wgt_addr_reg;
  logic [DATA_W-1:0]   mem_data_reg;
  logic                acc_start_reg;
  logic                res_valid_reg;
  logic [3:0]          res_label_reg;
  logic                res_timeout_reg;
  logic                load_state;
  logic                word_hs;

  // Ready is a pure state decode so the PIC->WGT boundary needs no bubble.
  assign load_state = (state_reg == LOAD_PIC) || (state_reg == LOAD_WGT);
  assign word_hs    = s_valid && load_state;

  assign s_ready     = load_state;
  assign seq_busy    = (state_reg != IDLE);
  assign pic_we      = pic_we_reg;
  assign pic_addr    = pic_addr_reg;
  assign wgt_we      = wgt_we_reg;
  assign wgt_addr    = wgt_addr_reg;
  assign mem_data    = mem_data_reg;
  assign acc_start   = acc_start_reg;
  assign res_valid   = res_valid_reg;
  assign res_label   = res_label_reg;
  assign res_timeout = res_timeout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      tcnt_reg        <= '0;
      skip_reg        <= 1'b0;
      pic_we_reg      <= 1'b0;
      pic_addr_reg    <= '0;
      wgt_we_reg      <= 1'b0;
      wgt_addr_reg    <= '0;
      mem_data_reg    <= '0;
      acc_start_reg   <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_label_reg   <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      pic_we_reg    <= 1'b0;
      wgt_we_reg    <= 1'b0;
      acc_start_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_go) begin
            skip_reg  <= cmd_skip_wgt;
            cnt_reg   <= '0;
            state_reg <= LOAD_PIC;
          end
        end

        LOAD_PIC: begin
          if (word_hs) begin
            pic_we_reg   <= 1'b1;
            pic_addr_reg <= cnt_reg[ADDR_W-1:0];
            mem_data_reg <= s_data;
            if (cnt_reg == PIC_LAST) begin
              cnt_reg   <= '0;
              state_reg <= skip_reg ? FLUSH : LOAD_WGT;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        LOAD_WGT: begin
          if (word_hs) begin
            wgt_we_reg   <= 1'b1;
            wgt_addr_reg <= cnt_reg[ADDR_W-1:0];
            mem_data_reg <= s_data;
            if (cnt_reg == WGT_LAST) begin
              cnt_reg   <= '0;
              state_reg <= FLUSH;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        // The last write strobe is on the wire during FLUSH; start follows it.
        FLUSH: begin
          acc_start_reg <= 1'b1;
          state_reg     <= START;
        end

        START: begin
          tcnt_reg  <= '0;
          state_reg <= WAIT;
        end

        WAIT: begin
          if (acc_done) begin
            res_label_reg   <= acc_label;
            res_timeout_reg <= 1'b0;
            res_valid_reg   <= 1'b1;
            state_reg       <= RESULT;
          end else if (tcnt_reg == TCNT_LAST) begin
            res_label_reg   <= '0;
            res_timeout_reg <= 1'b1;
            res_valid_reg   <= 1'b1;
            state_reg       <= RESULT;
          end else begin
            tcnt_reg <= tcnt_reg + TCNT_W'(1);
          end
        end

        RESULT: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Directed self-checking bench for accel_job_sequencer (PIC_WORDS=4, WGT_WORDS=3, TIMEOUT_CYC=20).
module tb_accel_job_sequencer;

  localparam int DATA_W      = 64;
  localparam int ADDR_W      = 7;
  localparam int PIC_WORDS   = 4;
  localparam int WGT_WORDS   = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int LOG_N       = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_go;
  logic              cmd_skip_wgt;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              pic_we;
  logic [ADDR_W-1:0] pic_addr;
  logic              wgt_we;
  logic [ADDR_W-1:0] wgt_addr;
  logic [DATA_W-1:0] mem_data;
  logic              acc_start;
  logic              acc_done;
  logic [3:0]        acc_label;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_label;
  logic              res_timeout;
  logic              seq_busy;

  accel_job_sequencer #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .PIC_WORDS   (PIC_WORDS),
    .WGT_WORDS   (WGT_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_go       (cmd_go),
    .cmd_skip_wgt (cmd_skip_wgt),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .pic_we       (pic_we),
    .pic_addr     (pic_addr),
    .wgt_we       (wgt_we),
    .wgt_addr     (wgt_addr),
    .mem_data     (mem_data),
    .acc_start    (acc_start),
    .acc_done     (acc_done),
    .acc_label    (acc_label),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_label    (res_label),
    .res_timeout  (res_timeout),
    .seq_busy     (seq_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/start log sampled mid-cycle; cumulative, jobs index from a snapshot.
  logic [ADDR_W-1:0] pic_a   [LOG_N];
  logic [DATA_W-1:0] pic_dat [LOG_N];
  logic [ADDR_W-1:0] wgt_a   [LOG_N];
  logic [DATA_W-1:0] wgt_dat [LOG_N];
  int n_pic = 0, n_wgt = 0, n_start = 0, n_both = 0;
  int last_hs = 0, last_wgt = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (pic_we === 1'b1) begin
      if (n_pic < LOG_N) begin
        pic_a[n_pic]   = pic_addr;
        pic_dat[n_pic] = mem_data;
      end
      n_pic++;
    end
    if (wgt_we === 1'b1) begin
      if (n_wgt < LOG_N) begin
        wgt_a[n_wgt]   = wgt_addr;
        wgt_dat[n_wgt] = mem_data;
      end
      n_wgt++;
      last_wgt = cyc;
    end
    if (pic_we === 1'b1 && wgt_we === 1'b1) n_both++;
    if (s_valid === 1'b1 && s_ready === 1'b1) last_hs = cyc;
    if (acc_start === 1'b1) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},     s_ready,     0);
    check({tag, "_pic_we"},      pic_we,      0);
    check({tag, "_pic_addr"},    pic_addr,    0);
    check({tag, "_wgt_we"},      wgt_we,      0);
    check({tag, "_wgt_addr"},    wgt_addr,    0);
    check({tag, "_mem_data"},    mem_data,    0);
    check({tag, "_acc_start"},   acc_start,   0);
    check({tag, "_res_valid"},   res_valid,   0);
    check({tag, "_res_label"},   res_label,   0);
    check({tag, "_res_timeout"}, res_timeout, 0);
    check({tag, "_seq_busy"},    seq_busy,    0);
  endtask

  // Offers n words base, base+1, ...; toggle=1 drops valid on alternate cycles.
  task automatic send_words(input string tag, input int n, input logic [63:0] base, input bit toggle);
    int sent = 0;
    int budget = 0;
    bit ph = 1'b1;
    logic hs;
    while (sent < n && budget < 100) begin
      s_valid = toggle ? ph : 1'b1;
      s_data  = base + 64'(sent);
      hs = s_valid && s_ready;
      step();
      if (hs) sent++;
      ph = ~ph;
      budget++;
    end
    s_valid = 1'b0;
    check({tag, "_words_sent"}, sent, n);
  endtask

  task automatic check_writes(input string tag, input int pb, input int np, input logic [63:0] pd,
                              input int wb, input int nw, input logic [63:0] wd);
    check({tag, "_pic_count"}, n_pic - pb, np);
    check({tag, "_wgt_count"}, n_wgt - wb, nw);
    for (int i = 0; i < np; i++) begin
      if (pb + i < LOG_N) begin
        check($sformatf("%s_pic_addr%0d", tag, i), pic_a[pb + i], i);
        check($sformatf("%s_pic_data%0d", tag, i), pic_dat[pb + i], pd + 64'(i));
      end
    end
    for (int i = 0; i < nw; i++) begin
      if (wb + i < LOG_N) begin
        check($sformatf("%s_wgt_addr%0d", tag, i), wgt_a[wb + i], i);
        check($sformatf("%s_wgt_data%0d", tag, i), wgt_dat[wb + i], wd + 64'(i));
      end
    end
  endtask

  int pb, wb, sb, n;

  initial begin
    rst_n = 1'b0; cmd_go = 1'b0; cmd_skip_wgt = 1'b0; s_valid = 1'b0; s_data = '0;
    acc_done = 1'b0; acc_label = '0; res_ready = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("idle_busy", seq_busy, 0);
    check("idle_ready", s_ready, 0);

    // Job 1: back-to-back words, then done with label 7 and a stalled result reader.
    pb = n_pic; wb = n_wgt; sb = n_start;
    cmd_go = 1'b1; step(); cmd_go = 1'b0;
    check("j1_busy", seq_busy, 1);
    check("j1_ready", s_ready, 1);
    send_words("j1", 7, 64'h10, 1'b0);
    s_valid = 1'b1; s_data = 64'h99;
    check("j1_flush_ready", s_ready, 0);
    check("j1_flush_wgt_we", wgt_we, 1);
    check("j1_flush_start", acc_start, 0);
    step();
    check("j1_start", acc_start, 1);
    check("j1_start_wgt_we", wgt_we, 0);
    step();
    check("j1_start_pulse", acc_start, 0);
    check("j1_wait_ready", s_ready, 0);
    s_valid = 1'b0;
    check_writes("j1", pb, 4, 64'h10, wb, 3, 64'h14);
    check("j1_n_start", n_start - sb, 1);
    check("j1_start_after_wgt", start_cyc - last_wgt, 1);
    acc_label = 4'd7;
    repeat (3) step();
    check("j1_wait_noresult", res_valid, 0);
    acc_done = 1'b1;
    step();
    acc_done = 1'b0; acc_label = 4'd0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("j1_res_valid%0d", i), res_valid, 1);
      check($sformatf("j1_res_label%0d", i), res_label, 7);
      check($sformatf("j1_res_timeout%0d", i), res_timeout, 0);
      step();
    end
    check("j1_res_hold", res_valid, 1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("j1_res_taken", res_valid, 0);
    check("j1_idle", seq_busy, 0);

    // Job 2: valid toggling, then no done -> timeout.
    pb = n_pic; wb = n_wgt;
    cmd_go = 1'b1; step(); cmd_go = 1'b0;
    send_words("j2", 7, 64'h10, 1'b1);
    check("j2_ready_after7", s_ready, 0);
    step();
    check("j2_start", acc_start, 1);
    check_writes("j2", pb, 4, 64'h10, wb, 3, 64'h14);
    acc_label = 4'd5;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("j2_timeout_steps", n, 21);
    check("j2_res_valid", res_valid, 1);
    check("j2_res_timeout", res_timeout, 1);
    check("j2_res_label", res_label, 0);
    acc_label = 4'd0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("j2_idle", seq_busy, 0);

    // Job 3: skip weights; done arrives on the timeout cycle.
    pb = n_pic; wb = n_wgt;
    cmd_go = 1'b1; cmd_skip_wgt = 1'b1; step(); cmd_go = 1'b0; cmd_skip_wgt = 1'b0;
    send_words("j3", 4, 64'h20, 1'b0);
    check("j3_flush_ready", s_ready, 0);
    check("j3_flush_pic_we", pic_we, 1);
    step();
    check("j3_start", acc_start, 1);
    step();
    check_writes("j3", pb, 4, 64'h20, wb, 0, 64'h0);
    check("j3_start_after_hs", start_cyc - last_hs, 2);
    repeat (19) step();
    check("j3_no_early_result", res_valid, 0);
    acc_done = 1'b1; acc_label = 4'd9;
    step();
    acc_done = 1'b0; acc_label = 4'd0;
    check("j3_res_valid", res_valid, 1);
    check("j3_res_timeout", res_timeout, 0);
    check("j3_res_label", res_label, 9);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("j3_idle", seq_busy, 0);

    // Job 4: reset in the middle of the weight load.
    cmd_go = 1'b1; step(); cmd_go = 1'b0;
    send_words("j4", 5, 64'h30, 1'b0);
    s_valid = 1'b1; s_data = 64'h35;
    check("j4_in_wgt_ready", s_ready, 1);
    check("j4_in_wgt_we", wgt_we, 1);
    rst_n = 1'b0;
    step();
    check_all_zero("j4_rst");
    rst_n = 1'b1; s_valid = 1'b0;
    step();
    check("j4_after_rst_busy", seq_busy, 0);

    // Job 5: fresh skip job; cmd_go during WAIT must not queue a new job.
    pb = n_pic; wb = n_wgt;
    cmd_go = 1'b1; cmd_skip_wgt = 1'b1; step(); cmd_go = 1'b0; cmd_skip_wgt = 1'b0;
    send_words("j5", 4, 64'h40, 1'b0);
    step();
    step();
    check_writes("j5", pb, 4, 64'h40, wb, 0, 64'h0);
    cmd_go = 1'b1; step(); cmd_go = 1'b0;
    check("j5_wait_busy", seq_busy, 1);
    check("j5_wait_ready", s_ready, 0);
    check("j5_wait_res", res_valid, 0);
    acc_done = 1'b1; acc_label = 4'd3;
    step();
    acc_done = 1'b0; acc_label = 4'd0;
    check("j5_res_label", res_label, 3);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("j5_idle_busy%0d", i), seq_busy, 0);
      check($sformatf("j5_idle_ready%0d", i), s_ready, 0);
      step();
    end
    check("both_we_never", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
